sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU's instruction-fetch requester and its load/store requester.
- Each requester uses a req/addr_ok/data_ok handshake. Responses return one cycle after grant, and grants may be issued back-to-back.
- Data accesses have fixed priority over fetch, with a bounded-starvation guard that forces a fetch grant.
- Sits between the multi-cycle CPU core and a unified code+data SRAM.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits before fetch is forced; legal range 1..15.
- CNT_W, 16: width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  fetch word address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request; held with fields until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid, or store complete
- data_rdata  out  32  load data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en
- conflict_cnt  out  CNT_W  cycles in which both requested and one was refused

Behaviour:
- Reset (resetn low, asynchronous):
  - resp_owner=NONE, streak=0, conflict_cnt=0.
  - All *_ok outputs and sram_en are 0; sram_we=0.
  - A response outstanding at reset is dropped. No data_ok appears after reset release.
- Grant logic is combinational from inputs and registers. At most one grant per cycle.
  - Only data_req: grant data.
  - Only inst_req: grant inst.
  - Both, and streak < STARVE_LIMIT: grant data.
  - Both, and streak == STARVE_LIMIT: grant inst.
- On a grant in cycle N:
  - Assert the winner's addr_ok.
  - Assert sram_en=1 and sram_addr = winner address.
  - Data store: sram_we=data_wstrb, sram_wdata=data_wdata.
  - Otherwise: sram_we=0, sram_wdata=0.
- No grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- resp_owner register is loaded at each clock edge with the granted requester (INST, DATA, or NONE).
- Cycle N+1, resp_owner=INST: inst_data_ok=1, inst_rdata=sram_rdata.
- Cycle N+1, resp_owner=DATA: data_data_ok=1, data_rdata=sram_rdata.
  - For a store, data_rdata is don't-care.
- Non-owner rdata outputs are 0. A new grant may occur in N+1, giving one access per cycle at full throughput.
- Store with data_wstrb=0: still granted; sram_we=0; data_data_ok still returned in N+1.
- streak:
  - Increments (saturating at STARVE_LIMIT) on a data grant while inst_req=1.
  - Clears on an inst grant, or on any cycle with inst_req=0.
- conflict_cnt: increments by 1 in every cycle where inst_req & data_req; saturates at all-ones.
- Requesters must keep req and fields stable until addr_ok. Dropping req before addr_ok is illegal; the arbiter does not check it.
- No address alignment checks; addresses pass through unmodified.
- Latency: addr_ok is in the request cycle at the earliest; data_ok is exactly 1 cycle after addr_ok.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - owner encoding constants OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2;
  - WSTRB_ALL=4'hf.
- One natural sub-module: sram_arb_starve_ctr.
  - Holds the streak counter and the force_inst output.
  - Inputs: inst_req, data grant, inst grant.
- Remaining logic (grant mux, resp_owner, conflict_cnt) stays in the top.

Test Plan:
- Reset, then inst_req only, addr 0x1c000000, SRAM word 0x02800421:
  - inst_addr_ok=1 in cycle 0;
  - inst_data_ok=1 with inst_rdata=0x02800421 in cycle 1;
  - data_data_ok stays 0.
- Simultaneous inst_req (addr 0x1c000004) and data load (addr 0x1c008000, SRAM word 0xdeadbeef):
  - data granted first, data_rdata=0xdeadbeef next cycle;
  - inst granted the following cycle;
  - conflict_cnt=1.
- Store, data_wstrb=4'b0011, addr 0x100, wdata 0x12345678:
  - sram_we=4'b0011 and sram_wdata=0x12345678 in the grant cycle;
  - data_data_ok the next cycle;
  - a later load of 0x100 returns the low half 0x5678 updated.
- Continuous data_req with inst_req held, STARVE_LIMIT=4:
  - exactly 4 data grants, then 1 inst grant, then data resumes;
  - repeating pattern, no fetch waits longer than 5 cycles.
- Back-to-back inst requests for 8 cycles, addrs 0x0,0x4,…:
  - addr_ok every cycle;
  - data_ok every cycle from cycle 1, rdata in address order.
- Assert resetn=0 in the cycle after a load grant:
  - data_data_ok never asserts;
  - after release, all outputs 0 and conflict_cnt=0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory path.
// Covers the response-owner encoding and the full-word store strobe.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] WSTRB_ALL = 4'hf;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Counts consecutive data wins while a fetch is waiting.
// Raises force_inst once the limit is reached, so the fetch is guaranteed the next grant.
module sram_arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_grant,
    input  logic inst_grant,
    output logic force_inst
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    // The streak is only meaningful while the fetch keeps waiting, so any idle fetch cycle clears it.
    always_comb begin
        streak_d = streak_q;
        if (inst_grant || !inst_req) begin
            streak_d = '0;
        end else if (data_grant && (streak_q != LIMIT)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_inst = (streak_q == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store.
// Data has priority; a starvation guard periodically forces a fetch grant.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic [31:0]      inst_addr,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             sram_en,
    output logic [3:0]       sram_we,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic   grant_inst;
    logic   grant_data;
    logic   force_inst;
    logic   conflict;
    owner_e resp_owner_q;
    owner_e resp_owner_d;
    logic [CNT_W-1:0] conflict_cnt_q;
    logic [CNT_W-1:0] conflict_cnt_d;

    sram_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .inst_req  (inst_req),
        .data_grant(grant_data),
        .inst_grant(grant_inst),
        .force_inst(force_inst)
    );

    // Grants are gated by resetn so no handshake or SRAM access leaks out while reset is held.
    always_comb begin
        conflict   = inst_req && data_req;
        grant_data = resetn && data_req && !(inst_req && force_inst);
        grant_inst = resetn && inst_req && !grant_data;
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst || grant_data;
        sram_we      = '0;
        sram_addr    = '0;
        sram_wdata   = '0;
        resp_owner_d = OWN_NONE;
        if (grant_data) begin
            sram_addr    = data_addr;
            resp_owner_d = OWN_DATA;
            if (data_wr) begin
                sram_we    = data_wstrb;
                sram_wdata = data_wdata;
            end
        end else if (grant_inst) begin
            sram_addr    = inst_addr;
            resp_owner_d = OWN_INST;
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && !(&conflict_cnt_q)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_owner_q   <= OWN_NONE;
            conflict_cnt_q <= '0;
        end else begin
            resp_owner_q   <= resp_owner_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // SRAM read data is routed only to the requester that owns this cycle's response.
    always_comb begin
        inst_data_ok = (resp_owner_q == OWN_INST);
        data_data_ok = (resp_owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? sram_rdata : '0;
        data_rdata   = data_data_ok ? sram_rdata : '0;
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule
